transpose_pingpong_buf: RTL

- Double-buffered successor to the single-bank transpose delay buffer.
- Accepts a full DEPTH-entry array in one cycle into an idle bank; drains the other bank one entry per cycle over a valid/ready stream.
- Sustains one output entry per cycle, with no bubbles between arrays.
- Sits between the systolic-array result collector and downstream row consumers; a per-load direction bit selects forward or reversed drain order.

---
 rtl/transpose_pingpong_buf.sv | 102 ++++++++++
 1 files changed

// File: rtl/transpose_pingpong_buf.sv
// Double-buffered transpose buffer: loads a whole DEPTH-entry array in one cycle
// into the idle bank while the other bank drains one entry per cycle, forward or reversed.
module transpose_pingpong_buf #(
    parameter int DEPTH = 8,
    parameter int BITS  = 64,
    parameter int IDXW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [BITS-1:0] load_data [DEPTH],
    input  logic            load_rev,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_data,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last,
    output logic [1:0]      count
);

    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("transpose_pingpong_buf: DEPTH must be >= 2");
        end
    endgenerate

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

    logic [BITS-1:0] bank_data [2][DEPTH];
    logic [1:0]      full;
    logic [1:0]      rev;
    logic            wr_sel;
    logic            rd_sel;
    logic [IDXW-1:0] rd_cnt;

    logic            load_fire;
    logic            beat;
    logic            last_beat;

    // Handshakes depend on registered state only, so load_ready never sees out_ready.
    assign load_ready = !full[wr_sel];
    assign load_fire  = load_valid && load_ready;

    assign out_valid  = full[rd_sel];
    assign out_idx    = rev[rd_sel] ? (LAST_IDX - rd_cnt) : rd_cnt;
    assign out_data   = out_valid ? bank_data[rd_sel][out_idx] : '0;
    assign out_last   = out_valid && (rd_cnt == LAST_IDX);

    assign beat       = out_valid && out_ready;
    assign last_beat  = beat && out_last;

    // Bank contents carry no reset; full flags keep stale data off out_data.
    always_ff @(posedge clk) begin
        if (load_fire && !flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_data[wr_sel][i] <= load_data[i];
            end
        end
    end

    // A load and a drain never target the same bank: loads need an empty bank, drains a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= '0;
            rev    <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            rd_cnt <= '0;
            count  <= '0;
        end else if (flush) begin
            full   <= '0;
            rev    <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            rd_cnt <= '0;
            count  <= '0;
        end else begin
            if (load_fire) begin
                full[wr_sel] <= 1'b1;
                rev[wr_sel]  <= load_rev;
                wr_sel       <= ~wr_sel;
            end
            if (beat) begin
                if (out_last) begin
                    rd_cnt       <= '0;
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= ~rd_sel;
                end else begin
                    rd_cnt <= rd_cnt + IDXW'(1);
                end
            end
            case ({load_fire, last_beat})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
